// File: rtl/lfsr_prbs_stream_if.sv
// Valid/ready word stream carrying PRBS words out of lfsr_prbs_stream.
interface lfsr_prbs_stream_if #(
  parameter int P_OUT_W = 8
);
  logic [P_OUT_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/lfsr_prbs_stream.sv
// Parametrised Fibonacci LFSR emitting P_OUT_W-bit words on a valid/ready stream.
// Optional period monitor enabled by defining LFSR_PERIOD_MON_EN.
module lfsr_prbs_stream #(
  parameter int             P_W         = 23,
  parameter logic [P_W-1:0] P_TAPS      = 23'h400010,
  parameter int             P_OUT_W     = 8,
  parameter int             P_CNT_W     = 16,
  parameter logic [P_W-1:0] P_INIT_SEED = 23'd4790770
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_W-1:0]     seed,
  input  logic               seed_wr,
  output logic               seed_rej,
  input  logic               start,
  input  logic [P_CNT_W-1:0] burst_len,
  input  logic               stop,
  output logic               busy,
  output logic               done,
`ifdef LFSR_PERIOD_MON_EN
  output logic               period_wrap,
  output logic [63:0]        period_cnt,
`endif
  lfsr_prbs_stream_if.master m
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [P_W-1:0]       sr_q, sr_d;
  logic [P_CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_OUT_W-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rej_q, rej_d;

  logic [P_W-1:0]       walk_s;
  logic [P_W-1:0]       sr_adv_s;
  logic [P_OUT_W-1:0]   word_s;
  logic                 y_s;
  logic                 load_s;
  logic                 seed_ok_s;

`ifdef LFSR_PERIOD_MON_EN
  logic [P_W-1:0]       ref_q, ref_d;
  logic [63:0]          step_q, step_d;
  logic [63:0]          pcnt_q, pcnt_d;
  logic                 wrap_q, wrap_d;
  logic                 hit_s;
  logic [63:0]          hit_step_s;
`endif

  // A word is only loaded in RUN; stop wins over a load in the same cycle.
  assign load_s    = (state_q == ST_RUN) && !stop && (!valid_q || m.m_ready);
  assign seed_ok_s = (state_q == ST_IDLE) && seed_wr && (seed != {P_W{1'b0}});

  // Unroll P_OUT_W LFSR steps; first feedback bit lands in the word MSB.
  always_comb begin
    walk_s = sr_q;
    word_s = {P_OUT_W{1'b0}};
    y_s    = 1'b0;
`ifdef LFSR_PERIOD_MON_EN
    hit_s      = 1'b0;
    hit_step_s = 64'd0;
`endif
    for (int k = 0; k < P_OUT_W; k++) begin
      y_s                   = ^(walk_s & P_TAPS);
      word_s[P_OUT_W-1-k]   = y_s;
      walk_s                = {walk_s[P_W-2:0], y_s};
`ifdef LFSR_PERIOD_MON_EN
      hit_step_s = (!hit_s && (walk_s == ref_q)) ? 64'(k + 1) : hit_step_s;
      hit_s      = hit_s | (walk_s == ref_q);
`endif
    end
    sr_adv_s = walk_s;
  end

  // Next-state logic for the FSM, burst counter, LFSR and output register.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seed_ok_s) begin
          sr_d = seed;
        end else begin
          rej_d = seed_wr;
        end
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = burst_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rej_d = seed_wr;
        // cnt_q == 0 in RUN means continuous mode.
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (load_s && (cnt_q == P_CNT_W'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
        if (load_s && (cnt_q != {P_CNT_W{1'b0}})) begin
          cnt_d = cnt_q - P_CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        rej_d = seed_wr;
        if (!valid_q || m.m_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load_s) begin
      data_d  = word_s;
      valid_d = 1'b1;
      sr_d    = sr_adv_s;
    end else if (valid_q && m.m_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= P_INIT_SEED;
      cnt_q   <= {P_CNT_W{1'b0}};
      data_q  <= {P_OUT_W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  // Period monitor: steps since the last reference capture, latched on a wrap.
  always_comb begin
    ref_d  = ref_q;
    step_d = step_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    if (seed_ok_s) begin
      ref_d  = seed;
      step_d = 64'd0;
    end else if (load_s && hit_s) begin
      wrap_d = 1'b1;
      pcnt_d = step_q + hit_step_s;
      step_d = 64'(P_OUT_W) - hit_step_s;
    end else if (load_s) begin
      step_d = step_q + 64'(P_OUT_W);
    end else begin
      step_d = step_q;
    end
  end

  // Period monitor registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q  <= P_INIT_SEED;
      step_q <= 64'd0;
      pcnt_q <= 64'd0;
      wrap_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      step_q <= step_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign period_wrap = wrap_q;
  assign period_cnt  = pcnt_q;
`endif

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign seed_rej  = rej_q;

endmodule
